wb_bus_arbiter: RTL and testbench
=================================

// Module: wb_bus_arbiter
// PURPOSE
//  Round-robin arbiter for the shared Wishbone bus (classic cycles). It grants one of NUMM masters,
//  e.g. ibex instr/data ports, access to the shared slave path and holds the grant for the whole
//  CYC burst. A bus watchdog terminates any stalled transfer with an error.
//  Sits between the master wb_if ports and the shared-bus interconnect mux, which it drives.
// PARAMETERS
//  NUMM     2     number of masters, 1..16
//  TIMEOUT  1024  cycles a strobed transfer may wait for ack/err before forced error; 0 = watchdog off
// PORTS
//  clk        in   1              system clock, all logic on rising edge
//  rst        in   1              asynchronous, active-high reset
//  cyc_i      in   NUMM           per-master CYC request
//  stb_i      in   NUMM           per-master STB
//  ack_i      in   1              ACK from shared slave path
//  err_i      in   1              ERR from shared slave path
//  gnt_o      out  NUMM           one-hot grant, registered
//  gnt_idx_o  out  $clog2(NUMM)   index of granted master; 0 when there is no grant
//  busy_o     out  1              any grant active (=|gnt_o)
//  timeout_o  out  1              watchdog error for the granted master (OR-ed into its ERR by the mux)
// BEHAVIOUR
//  Reset: gnt_o=0, gnt_idx_o=0, busy_o=0, timeout_o=0, counter=0, last=NUMM-1 (master 0 wins first).
//  Reset is honoured mid-transfer: all grants drop immediately. Slave-side cleanup is the slave's job.
//  States: IDLE (no grant), OWN (gnt_o[k]=1).
//  Arbitration ("pick"): choose the first i with cyc_i[i]=1, scanning last+1, last+2, ... modulo NUMM.
//  IDLE: if |cyc_i, pick winner w. Next cycle gnt_o=1<<w, last<=w, go to OWN. Latency is 1 cycle.
//  OWN(k):
//  - While cyc_i[k]=1, the grant is held. Other requests are ignored (no preemption).
//  - When cyc_i[k]=0, re-pick in the same cycle among all masters excluding k.
//    - If there is a winner, gnt_o switches directly to it next cycle, with no idle cycle.
//    - If there is none, go to IDLE.
//  - The granted master may re-request only after another requester has been served or the bus has idled.
//  gnt_o never has more than 1 bit set. gnt_o never changes while the granted cyc_i is high.
//  Watchdog, active only when TIMEOUT>0:
//  - Counter width is $clog2(TIMEOUT+1). It resets to 0 on grant change, on ack_i|err_i, or when
//    stb_i[k]=0.
//  - It increments while in OWN, stb_i[k]=1 and !ack_i && !err_i, and saturates; it never wraps.
//  - timeout_o = OWN && stb_i[k] && !ack_i && !err_i && cnt==TIMEOUT-1. This is combinational,
//    a single-cycle pulse, and the counter clears the next cycle.
//  - Simultaneous ack_i/err_i in the timeout cycle: the slave response wins and timeout_o stays 0.
//  - The grant is not revoked on timeout. The master sees ERR and ends its cycle normally.
//  ack_i/err_i in IDLE are ignored. NUMM=1: master 0 is granted whenever cyc_i[0]; arbitration is trivial.
// TESTING
//  1. Reset: hold rst 3 cycles with cyc_i=2'b11.
//     -> gnt_o=0 during reset; gnt_o=2'b01 one cycle after release.
//  2. Alternation: both masters hold cyc for 4 beats each, then drop and re-raise, for 8 bursts.
//     -> grants alternate 01,10,01,... with zero idle cycles between bursts.
//  3. Hold: master1 granted, master0 raises cyc mid-burst.
//     -> gnt_o stays 2'b10 until cyc_i[1] falls, then 2'b01 the next cycle.
//  4. Watchdog: TIMEOUT=16, granted stb held with no ack.
//     -> timeout_o high exactly on the 16th strobed cycle, for 1 cycle.
//     -> ack arriving on that cycle instead gives timeout_o=0.
//  5. Reset mid-burst: assert rst while gnt_o=2'b10.
//     -> gnt_o=0 at once; after release with cyc_i=11, master0 is granted first.
//  6. System run: ibex + shared-bus interconnect + spram running crc_32 for 43500 cycles.
//     -> no timeout_o, wb_checker clean, gnt_o always one-hot or zero.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone bus arbiter. The grant is held for a whole CYC burst, and a watchdog
// raises a one-cycle error when a strobed transfer stalls for too long.
module wb_bus_arbiter #(
  parameter int NUMM    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUMM-1:0]                      cyc_i,
  input  logic [NUMM-1:0]                      stb_i,
  input  logic                                 ack_i,
  input  logic                                 err_i,
  output logic [NUMM-1:0]                      gnt_o,
  output logic [((NUMM > 1) ? $clog2(NUMM) : 1)-1:0] gnt_idx_o,
  output logic                                 busy_o,
  output logic                                 timeout_o
);

  localparam int IW = (NUMM > 1) ? $clog2(NUMM) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, OWN} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   own_q, own_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NUMM-1:0] gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW:0]     pk;
  logic            stall, wd_hit, grant_chg;

  // Round-robin scan starting just after `start`; MSB of the result flags a winner.
  function automatic logic [IW:0] pick(input logic [NUMM-1:0] req, input logic [IW-1:0] start);
    logic          found;
    logic [IW-1:0] w;
    int            idx;
    found = 1'b0;
    w     = '0;
    for (int j = 1; j <= NUMM; j++) begin
      idx = (int'(start) + j) % NUMM;
      if (!found && req[idx]) begin
        found = 1'b1;
        w     = IW'(idx);
      end
    end
    return {found, w};
  endfunction

  assign stall  = (state_q == OWN) && stb_i[own_q] && !ack_i && !err_i;
  assign wd_hit = (TIMEOUT > 0) && stall && (cnt_q == TLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      own_q   <= '0;
      last_q  <= IW'(NUMM - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    pk      = '0;
    case (state_q)
      IDLE: begin
        pk = pick(cyc_i, last_q);
        if (pk[IW]) begin
          state_d = OWN;
          own_d   = pk[IW-1:0];
          last_d  = pk[IW-1:0];
        end
      end
      default: begin
        // The owner that just released is excluded so another requester gets a turn.
        if (!cyc_i[own_q]) begin
          pk = pick(cyc_i & ~(NUMM'(1) << own_q), own_q);
          if (pk[IW]) begin
            own_d  = pk[IW-1:0];
            last_d = pk[IW-1:0];
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase

    gnt_d     = (state_d == OWN) ? (NUMM'(1) << own_d) : '0;
    grant_chg = (state_d != OWN) || (own_d != own_q);

    cnt_d = cnt_q;
    if ((TIMEOUT == 0) || !stall || grant_chg || wd_hit) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    gnt_o     = gnt_q;
    busy_o    = |gnt_q;
    gnt_idx_o = (state_q == OWN) ? own_q : '0;
    timeout_o = wd_hit;
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter with two masters and a 16-cycle watchdog.
module tb_wb_bus_arbiter;

  logic       clk, rst;
  logic [1:0] cyc_i, stb_i;
  logic       ack_i, err_i;
  logic [1:0] gnt_o;
  logic [0:0] gnt_idx_o;
  logic       busy_o, timeout_o;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       rst;
    logic [1:0] cyc;
    logic [1:0] stb;
    logic       ack;
    logic       err;
    logic [1:0] gnt;
    logic       idx;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t sbq[$];
  vec_t tbl[17];

  wb_bus_arbiter #(.NUMM(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .cyc_i(cyc_i), .stb_i(stb_i), .ack_i(ack_i), .err_i(err_i),
    .gnt_o(gnt_o), .gnt_idx_o(gnt_idx_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [1:0] c, input logic [1:0] s,
                              input logic a, input logic e, input logic [1:0] g, input logic to);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.ack = a; v.err = e;
    v.gnt = g; v.idx = g[1]; v.busy = |g; v.to = to;
    return v;
  endfunction

  // Inputs are driven just after a rising edge; outputs are checked on the following falling edge.
  task automatic step(input string name, input vec_t v);
    vec_t e;
    rst = v.rst; cyc_i = v.cyc; stb_i = v.stb; ack_i = v.ack; err_i = v.err;
    sbq.push_back(v);
    @(negedge clk);
    e = sbq.pop_front();
    n_cmp++;
    if ({gnt_o, gnt_idx_o, busy_o, timeout_o} !== {e.gnt, e.idx, e.busy, e.to}) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b idx=%0d busy=%b to=%b, want gnt=%b idx=%0d busy=%b to=%b",
               name, gnt_o, gnt_idx_o, busy_o, timeout_o, e.gnt, e.idx, e.busy, e.to);
    end
    if (gnt_o === 2'b11) begin
      n_fail++;
      $display("FAIL onehot %s: got gnt=%b, want at most one bit", name, gnt_o);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cyc_i = 2'b11; stb_i = 2'b00; ack_i = 1'b0; err_i = 1'b0;

    tbl[0]  = mk(1, 2'b11, 2'b00, 0, 0, 2'b00, 0);
    tbl[1]  = mk(1, 2'b11, 2'b00, 0, 0, 2'b00, 0);
    tbl[2]  = mk(1, 2'b11, 2'b00, 0, 0, 2'b00, 0);
    tbl[3]  = mk(0, 2'b11, 2'b00, 0, 0, 2'b00, 0);
    tbl[4]  = mk(0, 2'b11, 2'b00, 0, 0, 2'b01, 0);
    tbl[5]  = mk(0, 2'b10, 2'b00, 0, 0, 2'b01, 0);
    tbl[6]  = mk(0, 2'b10, 2'b00, 0, 0, 2'b10, 0);
    tbl[7]  = mk(0, 2'b11, 2'b00, 0, 0, 2'b10, 0);
    tbl[8]  = mk(0, 2'b11, 2'b00, 0, 0, 2'b10, 0);
    tbl[9]  = mk(0, 2'b01, 2'b00, 0, 0, 2'b10, 0);
    tbl[10] = mk(0, 2'b01, 2'b00, 0, 0, 2'b01, 0);
    tbl[11] = mk(0, 2'b00, 2'b00, 0, 0, 2'b01, 0);
    tbl[12] = mk(0, 2'b00, 2'b00, 1, 1, 2'b00, 0);
    tbl[13] = mk(0, 2'b01, 2'b01, 0, 0, 2'b00, 0);
    tbl[14] = mk(0, 2'b01, 2'b01, 1, 0, 2'b01, 0);
    tbl[15] = mk(0, 2'b00, 2'b00, 0, 0, 2'b01, 0);
    tbl[16] = mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) step($sformatf("tbl%0d", i), tbl[i]);

    // Watchdog: stall with no response, pulse on the 16th strobed cycle only.
    step("wd_req", mk(0, 2'b01, 2'b01, 0, 0, 2'b00, 0));
    for (int n = 1; n <= 20; n++)
      step($sformatf("wd_stall%0d", n), mk(0, 2'b01, 2'b01, 0, 0, 2'b01, logic'(n == 16)));
    step("wd_drop", mk(0, 2'b00, 2'b00, 0, 0, 2'b01, 0));

    // Watchdog: ack on the would-be timeout cycle suppresses the pulse.
    step("wda_req", mk(0, 2'b01, 2'b01, 0, 0, 2'b00, 0));
    for (int n = 1; n <= 20; n++)
      step($sformatf("wda_stall%0d", n), mk(0, 2'b01, 2'b01, logic'(n == 16), 0, 2'b01, 0));
    step("wda_drop", mk(0, 2'b00, 2'b00, 0, 0, 2'b01, 0));
    step("wda_idle", mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 0));

    // Reset while master 1 owns the bus.
    step("rm_req", mk(0, 2'b10, 2'b10, 1, 0, 2'b00, 0));
    step("rm_own", mk(0, 2'b10, 2'b10, 1, 0, 2'b10, 0));
    step("rm_rst0", mk(1, 2'b11, 2'b11, 0, 0, 2'b00, 0));
    step("rm_rst1", mk(1, 2'b11, 2'b11, 0, 0, 2'b00, 0));
    step("rm_rel", mk(0, 2'b11, 2'b11, 1, 0, 2'b00, 0));

    // Alternation: 8 bursts of 4 beats, each owner drops cyc for one cycle; no idle gaps.
    for (int b = 0; b < 8; b++) begin
      logic [1:0] g;
      g = (b % 2 == 0) ? 2'b01 : 2'b10;
      for (int k = 0; k < 4; k++)
        step($sformatf("alt%0d_beat%0d", b, k), mk(0, 2'b11, 2'b11, 1, 0, g, 0));
      step($sformatf("alt%0d_drop", b), mk(0, ~g, ~g, 1, 0, g, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
